// File: rtl/input_conditioner.sv
// input_conditioner: 2-flop synchronisers and per-channel debounce FSMs for buttons (with press/release strobes) and switches.
// Define INPUT_SWITCH_DEBOUNCE_EN to debounce the switches too; otherwise Switch comes straight off the synchroniser.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [1:0] ButtonRaw,
    input  logic [1:0] SwitchRaw,
    output logic [1:0] Button,
    output logic [1:0] Switch,
    output logic [1:0] Press,
    output logic [1:0] Release
);
    typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef INPUT_SWITCH_DEBOUNCE_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 2;
`endif
    logic [3:0]     r_meta, r_sync;
    logic [NCH-1:0] w_level;
    logic [1:0]     w_btn_nx;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {SwitchRaw, ButtonRaw};
            r_sync <= r_meta;
        end
    end
    // Channels 0-1 are buttons, 2-3 (debounce build only) are switches.
    for (genvar g = 0; g < NCH; g++) begin : g_db
        state_t           r_state, w_state_nx;
        logic [CNT_W-1:0] r_cnt, w_cnt_nx;
        logic             r_level, w_level_nx;
        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                r_state <= STABLE_LO;
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_level <= w_level_nx;
            end
        end
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = '0;
            w_level_nx = r_level;
            case (r_state)
                STABLE_LO: if (r_sync[g]) w_state_nx = PEND_HI;
                PEND_HI:
                    if (!r_sync[g]) w_state_nx = STABLE_LO;
                    else if (r_cnt == LAST) begin
                        w_state_nx = STABLE_HI;
                        w_level_nx = 1'b1;
                    end else w_cnt_nx = r_cnt + 1'b1;
                STABLE_HI: if (!r_sync[g]) w_state_nx = PEND_LO;
                PEND_LO:
                    if (r_sync[g]) w_state_nx = STABLE_HI;
                    else if (r_cnt == LAST) begin
                        w_state_nx = STABLE_LO;
                        w_level_nx = 1'b0;
                    end else w_cnt_nx = r_cnt + 1'b1;
                default: w_state_nx = STABLE_LO;
            endcase
        end
        assign w_level[g] = r_level;
        if (g < 2) begin : g_btn
            assign w_btn_nx[g] = w_level_nx;
        end
    end
    // Strobes are registered alongside the level, so each fires the cycle the level changes.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Press   <= '0;
            Release <= '0;
        end else begin
            Press   <= w_btn_nx & ~Button;
            Release <= ~w_btn_nx & Button;
        end
    end
    assign Button = w_level[1:0];
`ifdef INPUT_SWITCH_DEBOUNCE_EN
    assign Switch = w_level[3:2];
`else
    assign Switch = r_sync[3:2];
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus against a run-length reference model of the debouncers.
module tb_input_conditioner;
    localparam int D = 4;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b1;
    logic [1:0] ButtonRaw = '0, SwitchRaw = '0;
    logic [1:0] Button, Switch, Press, Release;
    int checks = 0, errors = 0;
    logic [3:0] m_meta = '0, m_sync = '0, m_lvl = '0;
    logic [1:0] m_press = '0, m_rel = '0;
    int m_run [4] = '{0, 0, 0, 0};

    always #5 Clock = ~Clock;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .ButtonRaw(ButtonRaw), .SwitchRaw(SwitchRaw),
        .Button(Button), .Switch(Switch), .Press(Press), .Release(Release)
    );

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    // A level flips once the synchronised input has disagreed with it on D+1 consecutive edges.
    task automatic model_edge();
        if (!Reset_n) return;
        m_press = '0; m_rel = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_sync[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (i < 2) begin
                        if (m_lvl[i]) m_press[i] = 1'b1;
                        else m_rel[i] = 1'b1;
                    end
                end
            end else m_run[i] = 0;
        end
        m_sync = m_meta;
        m_meta = {SwitchRaw, ButtonRaw};
    endtask

    task automatic check();
        logic [1:0] exp_sw;
`ifdef INPUT_SWITCH_DEBOUNCE_EN
        exp_sw = m_lvl[3:2];
`else
        exp_sw = m_sync[3:2];
`endif
        checks += 4;
        assert (Button === m_lvl[1:0]) else begin errors++; $error("FAIL button got=%b exp=%b t=%0t", Button, m_lvl[1:0], $time); end
        assert (Switch === exp_sw) else begin errors++; $error("FAIL switch got=%b exp=%b t=%0t", Switch, exp_sw, $time); end
        assert (Press === m_press) else begin errors++; $error("FAIL press got=%b exp=%b t=%0t", Press, m_press, $time); end
        assert (Release === m_rel) else begin errors++; $error("FAIL release got=%b exp=%b t=%0t", Release, m_rel, $time); end
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
    endtask

    // Called away from the rising edge; returns at the falling edge.
    task automatic tick(input logic [1:0] b, input logic [1:0] s);
        ButtonRaw = b;
        SwitchRaw = s;
        @(posedge Clock);
        model_edge();
        #1 check();
        @(negedge Clock);
    endtask

    task automatic reset_pulse(input int n);
        Reset_n = 1'b0;
        model_reset();
        #1 check();
        repeat (n) tick(ButtonRaw, SwitchRaw);
        Reset_n = 1'b1;
    endtask

    // Edge index (0 = first edge sampling the new raw value) at which the chosen output changes.
    task automatic measure(input logic [1:0] b, input logic [1:0] s, input bit sw, input int ch,
                           input int lim, output int at, output int pulses);
        logic prev;
        prev = sw ? Switch[ch] : Button[ch];
        at = -1;
        pulses = 0;
        for (int k = 0; k < lim; k++) begin
            tick(b, s);
            if (!sw && (Press[ch] || Release[ch])) pulses++;
            if (at < 0 && (sw ? Switch[ch] : Button[ch]) !== prev) at = k;
        end
    endtask

    initial begin
        int at, pulses, idx;
        logic [3:0] raw;
        ButtonRaw = 2'b11;
        SwitchRaw = 2'b11;
        Reset_n = 1'b0;
        model_reset();
        #1 check();
        repeat (3) tick(2'b11, 2'b11);
        repeat (2) tick(2'b00, 2'b00);
        Reset_n = 1'b1;
        repeat (3) tick(2'b00, 2'b00);

        measure(2'b01, 2'b00, 1'b0, 0, 10, at, pulses);
        expect_int("clean_press_edge", at, 6);
        expect_int("clean_press_pulses", pulses, 1);
        measure(2'b00, 2'b00, 1'b0, 0, 10, at, pulses);
        expect_int("release_edge", at, 6);
        expect_int("release_pulses", pulses, 1);

        tick(2'b01, 2'b00); tick(2'b00, 2'b00); tick(2'b01, 2'b00); tick(2'b00, 2'b00);
        measure(2'b01, 2'b00, 1'b0, 0, 10, at, pulses);
        expect_int("bounce_edge", at, 6);
        expect_int("bounce_pulses", pulses, 1);

        measure(2'b11, 2'b00, 1'b0, 1, 10, at, pulses);
        expect_int("second_button_edge", at, 6);
        repeat (6) tick(2'b00, 2'b00);
        expect_int("simul_before", int'(Button), 3);
        tick(2'b00, 2'b00);
        expect_int("simul_button", int'(Button), 0);
        expect_int("simul_release", int'(Release), 3);
        tick(2'b00, 2'b00);
        expect_int("simul_release_end", int'(Release), 0);

        repeat (5) tick(2'b10, 2'b00);
        reset_pulse(2);
        measure(2'b10, 2'b00, 1'b0, 1, 12, at, pulses);
        expect_int("reset_mid_edge", at, 6);
        expect_int("reset_mid_pulses", pulses, 1);

        measure(2'b10, 2'b10, 1'b1, 1, 10, at, pulses);
`ifdef INPUT_SWITCH_DEBOUNCE_EN
        expect_int("switch_edge", at, 6);
        measure(2'b10, 2'b00, 1'b1, 1, 10, at, pulses);
        repeat (3) tick(2'b10, 2'b01);
        repeat (8) tick(2'b10, 2'b00);
        expect_int("switch_glitch", int'(Switch), 0);
`else
        expect_int("switch_edge", at, 1);
`endif

        for (int n = 0; n < 800; n++) begin
            raw = {SwitchRaw, ButtonRaw};
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) raw[idx] = ~raw[idx];
            if ($urandom_range(0, 199) == 0) reset_pulse($urandom_range(1, 3));
            else tick(raw[1:0], raw[3:2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
